// File: rtl/ped_request_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ped_request_arbiter
//  Description : Pedestrian crosswalk request arbiter. Synchronizes and
//                debounces the NS and EW buttons, latches presses as sticky
//                pending flags and presents one request at a time to the
//                light controller with round-robin tie-breaking and a
//                post-acknowledge lockout window.
//  Revision    : 1.0 - initial release
// ============================================================================
module ped_request_arbiter #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LOCKOUT_CYCLES  = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_ns,
    input  logic btn_ew,
    input  logic ack,
    output logic req,
    output logic req_dir,
    output logic pending_ns,
    output logic pending_ew
);

    // Counter width covers the full 1..255 parameter range.
    localparam int         c_CNT_W     = 8;
    localparam logic [7:0] c_DB_LAST   = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] c_LOCK_LAST = 8'(LOCKOUT_CYCLES - 1);

    // Handshake FSM encoding.
    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_REQ     = 2'd1;
    localparam logic [1:0] c_ST_LOCKOUT = 2'd2;

    // Button vector: index 0 = NS, index 1 = EW, matching the req_dir encoding.
    logic [1:0] w_btn;
    logic [1:0] w_rise;
    logic [1:0] w_clr;
    logic       w_sel_dir;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_lock_cnt;
    logic               r_req;
    logic               r_req_dir;
    logic               r_last_dir;
    logic [1:0]         r_pend;

    assign w_btn = {btn_ew, btn_ns};

    // Per-button synchronizer, debouncer and rising-edge detector.
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
        logic               r_sync1;
        logic               r_sync2;
        logic               r_db;
        logic               r_db_d;
        logic [c_CNT_W-1:0] r_cnt;

        // Two-flop synchronizer, then flip the debounced level after enough
        // consecutive disagreeing samples; any agreeing sample restarts the count.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_sync1 <= 1'b0;
                r_sync2 <= 1'b0;
                r_db    <= 1'b0;
                r_db_d  <= 1'b0;
                r_cnt   <= '0;
            end else begin
                r_sync1 <= w_btn[gi];
                r_sync2 <= r_sync1;
                r_db_d  <= r_db;
                if (r_sync2 != r_db) begin
                    if (r_cnt >= c_DB_LAST) begin
                        r_db  <= ~r_db;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end else begin
                    r_cnt <= '0;
                end
            end
        end

        // Only a debounced 0->1 transition counts as a new press.
        assign w_rise[gi] = r_db & ~r_db_d;
    end

    // Single pending flag wins outright; a tie goes to the direction not served last.
    always_comb begin
        w_sel_dir = ~r_last_dir;
        if (r_pend == 2'b01) begin
            w_sel_dir = 1'b0;
        end else if (r_pend == 2'b10) begin
            w_sel_dir = 1'b1;
        end
    end

    // Clear strobe for the served direction on an accepted acknowledge.
    always_comb begin
        w_clr = 2'b00;
        if ((r_state == c_ST_REQ) && ack) begin
            w_clr = {r_req_dir, ~r_req_dir};
        end
    end

    // Sticky pending flags; a new press on the clearing edge keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= 2'b00;
        end else begin
            r_pend <= (r_pend & ~w_clr) | w_rise;
        end
    end

    // Request handshake: IDLE -> REQ on pending, REQ -> LOCKOUT on ack,
    // LOCKOUT holds for the programmed number of edges before IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_lock_cnt <= '0;
            r_req      <= 1'b0;
            r_req_dir  <= 1'b0;
            r_last_dir <= 1'b1;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (|r_pend) begin
                        r_state   <= c_ST_REQ;
                        r_req     <= 1'b1;
                        r_req_dir <= w_sel_dir;
                    end
                end
                c_ST_REQ: begin
                    if (ack) begin
                        r_state    <= c_ST_LOCKOUT;
                        r_req      <= 1'b0;
                        r_last_dir <= r_req_dir;
                        r_lock_cnt <= c_LOCK_LAST;
                    end
                end
                c_ST_LOCKOUT: begin
                    if (r_lock_cnt == '0) begin
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_lock_cnt <= r_lock_cnt - 8'd1;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign req        = r_req;
    assign req_dir    = r_req_dir;
    assign pending_ns = r_pend[0];
    assign pending_ew = r_pend[1];

endmodule
`default_nettype wire

// File: doc/ped_request_arbiter.md
PED_REQUEST_ARBITER -- requirements
Module: ped_request_arbiter

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, SHALL set the consecutive stable samples needed to accept a button level change (legal range 1..255).
REQ-002 Parameter LOCKOUT_CYCLES, default 16, SHALL set the idle cycles enforced after each acknowledged request (legal range 1..255).
REQ-003 Port clk  input  1  system clock SHALL be the only clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset SHALL be synchronous and active-high.
REQ-005 Port btn_ns  input  1  raw asynchronous NS crosswalk button, active-high.
REQ-006 Port btn_ew  input  1  raw asynchronous EW crosswalk button, active-high.
REQ-007 Port ack  input  1  acknowledge from the light controller, active-high, level-sampled.
REQ-008 Port req  output  1  crossing request to the light controller.
REQ-009 Port req_dir  output  1  direction of the request, 0 = NS, 1 = EW.
REQ-010 Port pending_ns  output  1  NS press latched and not yet served.
REQ-011 Port pending_ew  output  1  EW press latched and not yet served.

Function
REQ-012 Each button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-013 Per button, the debounced level SHALL flip at the DEBOUNCE_CYCLES-th consecutive edge where the synchronized input differs from it; the counter SHALL clear on any edge where they match.
REQ-014 A debounced 0->1 transition SHALL set the matching pending flag on the following edge; 1->0 transitions and held levels SHALL have no effect.
REQ-015 Pending flags SHALL be sticky until cleared by an acknowledged request for that direction (REQ-019).
REQ-016 The handshake FSM SHALL have states IDLE, REQ, LOCKOUT; reset state IDLE.
REQ-017 IDLE: if either pending flag is 1, FSM SHALL enter REQ on the next edge, driving req=1 and req_dir = selected direction (REQ-018); otherwise stay IDLE with req=0.
REQ-018 Arbitration: if only one flag is set, select it; if both, select the direction opposite last_dir (round-robin); last_dir SHALL update to the selected direction at each ack.
REQ-019 REQ: req and req_dir SHALL be held stable until ack is sampled 1; on that edge the selected pending flag clears, FSM enters LOCKOUT, req drops to 0.
REQ-020 LOCKOUT: req=0 for exactly LOCKOUT_CYCLES edges, then IDLE; a pending flag may re-raise req no earlier than the edge after returning to IDLE.
REQ-021 ack sampled in IDLE or LOCKOUT SHALL be ignored.
REQ-022 Presses debounced during REQ or LOCKOUT SHALL still set pending flags; they SHALL NOT change req_dir of an outstanding request.
REQ-023 If a pending set and its clear coincide on one edge, set SHALL win (flag stays 1).
REQ-024 Latency: with DEBOUNCE_CYCLES=D, a clean press first sampled at edge 1 SHALL produce pending at edge 3+D and req at edge 4+D (edge 8 for D=4), given FSM in IDLE.
REQ-025 Counters SHALL saturate, never wrap; glitches shorter than D cycles SHALL never set a pending flag.

Reset
REQ-026 While rst=1: req=0, req_dir=0, pending_ns=0, pending_ew=0, FSM=IDLE, last_dir=1 (NS wins the first tie), synchronizers, debounced levels and all counters = 0.
REQ-027 rst asserted mid-handshake SHALL abandon the request and discard pending presses; behaviour after release SHALL match power-up.

Verification
REQ-028 Single press: btn_ns high 10 cycles from edge 1, ack tied 0 -> pending_ns=1 at edge 7, req=1 req_dir=0 at edge 8, held indefinitely.
REQ-029 Glitch reject: btn_ew pulses 3 cycles (D=4) -> pending_ew and req stay 0 throughout.
REQ-030 Tie arbitration: both buttons pressed same cycle -> first req_dir=0; ack 1 cycle -> pending_ns clears, 16 lockout cycles, next req_dir=1.
REQ-031 Lockout: ack while NS request open, then NS re-pressed during lockout -> pending_ns re-sets, req stays 0 until exactly 16 edges after ack, then rises with req_dir=0.
REQ-032 Stray ack: ack=1 in IDLE with no pending -> no state change; ack held high across REQ entry -> request acknowledged on first REQ edge.
REQ-033 Reset mid-REQ: rst for 1 cycle while req=1 and both pending -> all outputs 0 next edge; no req without new presses.
